// File: rtl/logic_unit_fifo.sv
// WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) whose results are queued in a
// DEPTH-entry result FIFO with valid/ready handshakes on both sides.
module logic_unit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             c_zero,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result;
  logic             push;
  logic             pop;

  always_comb begin
    result = '0;
    case (op)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = a ^ b;
      2'b11: result = ~(a | b);
    endcase
  end

  // Ready is a function of occupancy only, so a pop at full never opens a slot
  // for a push on the same edge.
  assign in_ready  = (cnt_q < FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage is not reset; the output mux below keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign c      = out_valid ? mem[rd_ptr] : '0;
  assign c_zero = out_valid & (c == '0);
  assign count  = cnt_q;

endmodule
